// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 codes, LSU state encoding and access legality check
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RESP
  } lsu_state_t;

  // Unsigned widths exist only for loads; halfwords need addr[0]=0, words addr[1:0]=0.
  function automatic logic access_illegal(input logic       we,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    logic ill;
    case (funct3)
      F3_B:    ill = 1'b0;
      F3_H:    ill = addr_lo[0];
      F3_W:    ill = (addr_lo != 2'b00);
      F3_BU:   ill = we;
      F3_HU:   ill = we | addr_lo[0];
      default: ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational load lane extract/extend and store lane merge
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [4:0]  byte_sh;

  always_comb begin
    byte_sh = {addr_lo, 3'b000};
    byte_v  = rdata[byte_sh +: 8];
    half_v  = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
      F3_H:    load_data = {{16{half_v[15]}}, half_v};
      F3_BU:   load_data = {24'h000000, byte_v};
      F3_HU:   load_data = {16'h0000, half_v};
      default: load_data = rdata;
    endcase

    store_word = rdata;
    case (funct3)
      F3_B: store_word[byte_sh +: 8] = wdata[7:0];
      F3_H: begin
        if (addr_lo[1]) store_word[31:16] = wdata[15:0];
        else            store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - RV32I load/store unit driving the word-wide RAM data port
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_t            state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] store_word;

  lsu_align u_align (
    .rdata      (mem_rdata),
    .wdata      (wdata_q),
    .addr_lo    (addr_q[1:0]),
    .funct3     (funct3_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (access_illegal(req_we, req_funct3, req_addr[1:0])) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (req_we && (req_funct3 == F3_W)) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        // wdata_q is reused to hold the merged word for the write cycle.
        if (we_q) begin
          wdata_d = store_word;
          state_d = S_WR;
        end else begin
          rdata_d = load_data;
          state_d = S_RESP;
        end
      end
      S_WR: begin
        rdata_d = '0;
        state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;
  assign mem_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata  = wdata_q;
  assign mem_we     = (state_q == S_WR);

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - scoreboard bench for data_mem_lsu with a RAM model
module tb_data_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, q_b;
  logic        mem_we;

  always #5 clk = ~clk;

  data_mem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(q_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic armed = 1'b0;
  logic clr;

  always @(posedge clk) cyc <= cyc + 1;

  // Write-first RAM, 64 words, registered read.
  logic [31:0] ram [0:63];
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
      q_b <= 32'h0;
    end else begin
      if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
      q_b <= mem_we ? mem_wdata : ram[mem_addr[7:2]];
    end
  end

  logic [31:0] shadow [0:63];

  typedef struct { logic [31:0] rdata; logic err; int due; } exp_resp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int due; } exp_wr_t;
  exp_resp_t resp_q[$];
  exp_wr_t   wr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  always @(negedge clk) begin
    exp_resp_t e;
    exp_wr_t   w;
    if (armed) begin
      if (resp_valid) begin
        if (resp_q.size() == 0) flag("unexpected_resp");
        else begin
          e = resp_q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
          check("resp_cycle", cyc, e.due);
        end
      end
      if (mem_we) begin
        if (wr_q.size() == 0) flag("unexpected_mem_we");
        else begin
          w = wr_q.pop_front();
          check("mem_addr", mem_addr, w.addr);
          check("mem_wdata", mem_wdata, w.data);
          check("mem_we_cycle", cyc, w.due);
        end
      end
    end
  end

  int last_accept;

  // Leaves req_valid high; the caller drops it with idle_wait.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    int n, e_t, idx, k;
    logic ill;
    logic [31:0] w, sh, r, nw, mask, ins;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      flag("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    e_t = cyc + 1;
    last_accept = e_t;
    idx = int'(addr[7:2]);
    ill = (f3 == 3 || f3 == 6 || f3 == 7) || (we && f3 >= 4) ||
          ((f3 == 1 || f3 == 5) && addr[0]) || (f3 == 2 && addr[1:0] != 0);
    if (ill) begin
      resp_q.push_back('{32'h0, 1'b1, e_t});
    end else if (we) begin
      w = shadow[idx];
      if (f3 == 2) begin
        nw = wdata; k = 2;
      end else begin
        k = 4;
        if (f3 == 0) begin
          mask = 32'hFF << (8 * addr[1:0]);
          ins  = (wdata & 32'hFF) << (8 * addr[1:0]);
        end else begin
          mask = 32'hFFFF << (16 * addr[1]);
          ins  = (wdata & 32'hFFFF) << (16 * addr[1]);
        end
        nw = (w & ~mask) | ins;
      end
      shadow[idx] = nw;
      wr_q.push_back('{addr & 32'hFFFF_FFFC, nw, e_t + k - 2});
      resp_q.push_back('{32'h0, 1'b0, e_t + k - 1});
    end else begin
      w  = shadow[idx];
      sh = w >> (8 * addr[1:0]);
      case (f3)
        3'd0: r = ((sh & 32'hFF) >= 128) ? ((sh & 32'hFF) | 32'hFFFF_FF00) : (sh & 32'hFF);
        3'd1: r = ((sh & 32'hFFFF) >= 32768) ? ((sh & 32'hFFFF) | 32'hFFFF_0000) : (sh & 32'hFFFF);
        3'd4: r = sh & 32'hFF;
        3'd5: r = sh & 32'hFFFF;
        default: r = w;
      endcase
      resp_q.push_back('{r, 1'b0, e_t + 2});
    end
    @(posedge clk);
  endtask

  task automatic idle_wait();
    int n;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while ((resp_q.size() != 0 || wr_q.size() != 0 || !req_ready) && n < 50) begin
      @(negedge clk); n++;
    end
    if (n >= 50) flag("drain_timeout");
  endtask

  initial begin
    int e1;
    int e_t;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 64; i++) shadow[i] = 32'h0;
    clr = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    armed = 1'b1;

    issue(1, 3'd2, 32'h10, 32'hDEADBEEF);
    issue(0, 3'd2, 32'h10, 32'h0);
    issue(1, 3'd2, 32'h20, 32'h80FF7F01);
    issue(0, 3'd0, 32'h23, 32'h0);
    issue(0, 3'd4, 32'h23, 32'h0);
    issue(0, 3'd0, 32'h21, 32'h0);
    issue(0, 3'd5, 32'h22, 32'h0);
    issue(1, 3'd2, 32'h08, 32'h11223344);
    issue(1, 3'd0, 32'h09, 32'h000000AA);
    issue(1, 3'd1, 32'h0A, 32'h0000BEEF);
    issue(0, 3'd2, 32'h08, 32'h0);
    issue(0, 3'd2, 32'h06, 32'h0);
    issue(1, 3'd1, 32'h05, 32'h1234);
    issue(0, 3'd3, 32'h00, 32'h0);
    issue(1, 3'd4, 32'h00, 32'h55);
    idle_wait();

    issue(0, 3'd2, 32'h10, 32'h0);
    e1 = last_accept;
    issue(0, 3'd2, 32'h20, 32'h0);
    check("b2b_accept_gap", last_accept - e1, 32'd4);
    idle_wait();

    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            32'($urandom_range(0, 255)), $urandom);
      if ($urandom_range(0, 3) == 0) idle_wait();
    end
    idle_wait();

    issue(1, 3'd2, 32'h40, 32'h11223344);
    idle_wait();
    // SB aborted by reset during CAP: nothing must reach the scoreboard.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h41; req_wdata = 32'h55;
    e_t = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_rd_cycle", cyc, e_t);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    check("abort_mem_addr", mem_addr, 32'h0);
    check("abort_resp_rdata", resp_rdata, 32'h0);
    repeat (6) @(negedge clk);
    check("abort_ram_word", ram[16], 32'h11223344);
    issue(0, 3'd2, 32'h40, 32'h0);
    idle_wait();

    check("resp_queue_empty", resp_q.size(), 32'd0);
    check("wr_queue_empty", wr_q.size(), 32'd0);
    for (int i = 0; i < 64; i++) check("ram_vs_model", ram[i], shadow[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Load/store unit that issues word-oriented requests to the data port (port B) of the shared instruction/data RAM on behalf of the core's execute stage. It converts RV32I byte, halfword and word loads and stores into single-word RAM accesses: it sign- or zero-extends load data and performs read-modify-write for sub-word stores, because the RAM has no byte enables. It also rejects misaligned or illegal accesses.

## Interface
- DATA_WIDTH, 32, data and RAM word width (only 32 supported)
- ADDR_WIDTH, 32, byte address width
- clk  in  1  rising-edge clock, shared with the RAM
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  LSU can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- resp_valid  out  1  one-cycle pulse: request complete
- resp_rdata  out  DATA_WIDTH  extended load data (0 for stores and errors)
- resp_err  out  1  valid with resp_valid: misaligned or illegal funct3
- mem_addr  out  ADDR_WIDTH  to RAM addr_b, always word-aligned ({addr[31:2],2'b00})
- mem_wdata  out  DATA_WIDTH  to RAM data_b
- mem_we  out  1  to RAM we_b
- mem_rdata  in  DATA_WIDTH  from RAM q_b (registered, valid one cycle after the address)

## Operation
- States: IDLE, RD, CAP, WR, RESP.
- IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata.
  - Illegal access goes to RESP with err=1. Illegal means: funct3 in {3,6,7}; store with funct3 4 or 5; halfword with addr[0]=1; word with addr[1:0]≠0.
  - A legal access goes to WR if it is a word store, otherwise to RD.
- RD: drive mem_addr, mem_we=0 → CAP.
- CAP: mem_rdata is valid.
  - Load: extract the byte at addr[1:0] or the halfword at addr[1]. Sign-extend for funct3 0/1, zero-extend for 4/5, pass through for 2. Store the result in the response register → RESP.
  - Sub-word store: merge the low byte or halfword of wdata into the read word at the lane given by addr → WR.
- WR: mem_addr, mem_wdata = merged or full word, mem_we=1 for exactly this cycle → RESP.
- RESP: resp_valid=1 for one cycle → IDLE. resp_rdata holds the value until the next RESP.
- All outputs are registered or decoded from the state register; no combinational path from req_* to mem_*.
- Errors never touch memory: mem_we stays 0 and resp_rdata=0.

## Timing
- Request accepted at edge T (IDLE and req_valid):
  - word store: WR T+1, resp_valid T+2
  - load: RD T+1, CAP T+2, resp_valid T+3
  - sub-word store: RD T+1, CAP T+2, WR T+3, resp_valid T+4
  - error: resp_valid T+1
- req_ready is low from T+1 until the cycle after RESP. req_valid is ignored outside IDLE.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation returns to IDLE at the next edge with no response. A write either committed at a WR edge already passed or never occurs, so the RMW never leaves a half-written word.
- The RAM is write-first on port B. Port A writes to the same word between RD and WR are not arbitrated; the core guarantees no self-modifying code during sub-word stores.
- Addresses above RAM depth alias per RAM indexing; the LSU performs no range check.

## Structure
- Package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - the state enum lsu_state_t
  - the align-check function
- Sub-module lsu_align: purely combinational.
  - Load extract: rdata, addr[1:0], funct3 → extended data.
  - Store merge: old word, wdata, addr[1:0], funct3 → new word.
  - Instantiated once in data_mem_lsu; reusable by a future instruction-fetch-side checker.

## Test plan
- Word store then load: SW 0xDEADBEEF @0x10 → mem_we pulse at T+1 with mem_addr=0x10; LW @0x10 → resp_rdata=0xDEADBEEF at T+3, err=0.
- Signed/unsigned bytes: word 0x80FF7F01 @0x20. LB @0x23 → 0xFFFFFF80. LBU @0x23 → 0x00000080. LB @0x21 → 0x0000007F. LHU @0x22 → 0x000080FF.
- Sub-word RMW: word 0x11223344 @0x8. SB 0xAA @0x9 → written word 0x1122AA44 at T+3. SH 0xBEEF @0xA → 0xBEEFAA44. The other bytes are unchanged.
- Misaligned/illegal: LW @0x6, SH @0x5, funct3=3, store funct3=4 → resp_err=1 at T+1, resp_rdata=0, mem_we never asserted.
- Handshake: hold req_valid high for back-to-back loads → req_ready low for cycles T+1..T+3, second request accepted at T+4, one resp_valid per request.
- Reset mid-RMW: assert rst_n=0 during CAP of an SB → no mem_we, no resp_valid, req_ready=1 the cycle after release, target word unchanged.
